div_share_arbiter: RTL

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_arb_pkg.sv | 17 +
 rtl/div_share_arbiter_rr_pick.sv | 31 +++
 rtl/div_share_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared FSM state type and watchdog constant for div_share_arbiter.
package div_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    // WAIT-state watchdog length, in cycles, for an n-bit shared divider.
    function automatic int unsigned timeout_cycles(input int unsigned n);
        return 2 * n + 8;
    endfunction

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; the search starts one past last_grant.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    // Walk the requesters in rotated order and take the first valid one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_grant) + k) % NREQ);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: serialises NREQ requesters onto one shared divider,
// one operation in flight at a time (IDLE -> CLR -> LAUNCH -> WAIT -> RESP).
// Optional feature: define DIV_ARB_TIMEOUT_EN to add a WAIT watchdog that
// forces a zero result flagged by the extra rsp_timeout output.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_x,
    input  logic [NREQ*N-1:0]  req_y,
    input  logic [NREQ-1:0]    req_signed,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [N-1:0]       rsp_q,
    output logic [N-1:0]       rsp_r,
    output logic               rsp_dbz,
`ifdef DIV_ARB_TIMEOUT_EN
    output logic               rsp_timeout,
`endif
    output logic               div_rst,
    output logic               div_start,
    output logic               div_signed,
    output logic [N-1:0]       div_x,
    output logic [N-1:0]       div_y,
    input  logic               div_done,
    input  logic               div_dbz,
    input  logic [N-1:0]       div_q,
    input  logic [N-1:0]       div_r
);

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned TO = timeout_cycles(N);
    localparam int          CW = $clog2(TO);
`endif

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [N-1:0]   x_q, x_d, y_q, y_d;
    logic           sgn_q, sgn_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rv_q, rv_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [N-1:0]   rq_q, rq_d, rr_q, rr_d;
    logic           rdbz_q, rdbz_d;
`ifdef DIV_ARB_TIMEOUT_EN
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rto_q, rto_d;
`endif

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid      (req_valid),
        .last_grant (last_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    // Next-state and next-register computation for the single-operation FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        id_d    = id_q;
        rv_d    = rv_q;
        rid_d   = rid_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        rdbz_d  = rdbz_q;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        rto_d   = rto_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // req_ready equals the picker grant here, so any valid is a handshake.
                if (pick_any) begin
                    x_d     = req_x[int'(pick_idx) * N +: N];
                    y_d     = req_y[int'(pick_idx) * N +: N];
                    sgn_d   = req_signed[pick_idx];
                    id_d    = pick_idx;
                    last_d  = pick_idx;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
`ifdef DIV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) begin
                    rv_d    = 1'b1;
                    rid_d   = id_q;
                    rq_d    = div_q;
                    rr_d    = div_r;
                    rdbz_d  = div_dbz;
`ifdef DIV_ARB_TIMEOUT_EN
                    rto_d   = 1'b0;
`endif
                    state_d = ST_RESP;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TO - 1)) begin
                    rv_d    = 1'b1;
                    rid_d   = id_q;
                    rq_d    = '0;
                    rr_d    = '0;
                    rdbz_d  = 1'b0;
                    rto_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register update; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            id_q    <= '0;
            rv_q    <= 1'b0;
            rid_q   <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            rdbz_q  <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            rto_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            id_q    <= id_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            rdbz_q  <= rdbz_d;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            rto_q   <= rto_d;
`endif
        end
    end

    // Grants only in IDLE and never while reset is applied.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && !rst) begin
            req_ready = pick_grant;
        end
    end

    assign div_rst    = rst | (state_q == ST_CLR);
    assign div_start  = (state_q == ST_LAUNCH);
    assign div_signed = sgn_q;
    assign div_x      = x_q;
    assign div_y      = y_q;

    assign rsp_valid  = rv_q;
    assign rsp_id     = rid_q;
    assign rsp_q      = rq_q;
    assign rsp_r      = rr_q;
    assign rsp_dbz    = rdbz_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign rsp_timeout = rto_q;
`endif

endmodule
